// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types for the unified-RAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int C_WORD_W = 32;

    typedef logic [C_WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RS_FREE   = 2'd0,
        RS_BUSY   = 2'd1,
        RS_ACCESS = 2'd2,
        RS_ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DGRANT = 3'd1,
        ST_IGRANT = 3'd2,
        ST_DRESP  = 3'd3,
        ST_IRESP  = 3'd4
    } arb_state_t;

    function automatic logic is_grant(input arb_state_t s);
        return (s == ST_DGRANT) || (s == ST_IGRANT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_streak_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : arb_streak_ctr
//  Description : Saturating count of consecutive data wins over a pending fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_streak_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_DSTREAK = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int              C_CW  = $clog2(MAX_DSTREAK + 1);
    localparam logic [C_CW-1:0] C_MAX = C_CW'(MAX_DSTREAK);

    logic [C_CW-1:0] r_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign sat = (r_count == C_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Fetch/data arbiter for the single-ported unified RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              memerr
);

    localparam int              C_TW    = $clog2(TIMEOUT + 1);
    localparam logic [C_TW-1:0] C_TLAST = C_TW'(TIMEOUT - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    ramstate_t         w_rs;
    logic [C_TW-1:0]   r_timer;
    logic              r_memerr;
    logic              w_memerr_set;
    logic [WORD_W-1:0] r_iload;
    logic [WORD_W-1:0] r_dload;
    logic              w_dreq;
    logic              w_access;
    logic              w_error;
    logic              w_timeout;
    logic              w_dcomplete;
    logic              w_icomplete;
    logic              w_streak_sat;

    assign w_rs        = ramstate_t'(ramstate);
    assign w_dreq      = dREN | dWEN;
    assign w_access    = (w_rs == RS_ACCESS);
    assign w_error     = (w_rs == RS_ERROR);
    assign w_timeout   = (r_timer == C_TLAST) && !w_access;
    assign w_dcomplete = (r_state == ST_DGRANT) && w_dreq && w_access;
    assign w_icomplete = (r_state == ST_IGRANT) && iREN && w_access;

    arb_streak_ctr #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_streak (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (w_dcomplete && iREN),
        .clr  (w_icomplete || !iREN),
        .sat  (w_streak_sat)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Withdrawal beats every RAM response so a dropped request never hits or errors.
    always_comb begin
        w_next       = r_state;
        w_memerr_set = 1'b0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        ihit         = 1'b0;
        dhit         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_dreq && !(iREN && w_streak_sat)) begin
                    w_next = ST_DGRANT;
                end else if (iREN) begin
                    w_next = ST_IGRANT;
                end
            end
            ST_DGRANT: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramstore = dstore;
                if (!w_dreq) begin
                    w_next = ST_IDLE;
                end else if (w_access) begin
                    w_next = ST_DRESP;
                end else if (w_error || w_timeout) begin
                    w_next       = ST_IDLE;
                    w_memerr_set = 1'b1;
                end
            end
            ST_IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (!iREN) begin
                    w_next = ST_IDLE;
                end else if (w_access) begin
                    w_next = ST_IRESP;
                end else if (w_error || w_timeout) begin
                    w_next       = ST_IDLE;
                    w_memerr_set = 1'b1;
                end
            end
            ST_DRESP: begin
                dhit   = 1'b1;
                w_next = ST_IDLE;
            end
            ST_IRESP: begin
                ihit   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_timer  <= '0;
            r_memerr <= 1'b0;
            r_iload  <= '0;
            r_dload  <= '0;
        end else begin
            r_memerr <= w_memerr_set;
            if (is_grant(r_state) && is_grant(w_next)) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
            if (w_icomplete) begin
                r_iload <= ramload;
            end
            if (w_dcomplete && !dWEN) begin
                r_dload <= ramload;
            end
        end
    end

    assign iload  = r_iload;
    assign dload  = r_dload;
    assign memerr = r_memerr;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a behavioural RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int C_MAX = 4;
    localparam int C_TO  = 8;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        ihit, dhit, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    mem_arbiter #(
        .WORD_W      (32),
        .MAX_DSTREAK (C_MAX),
        .TIMEOUT     (C_TO)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .ihit     (ihit),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .memerr   (memerr)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem [0:127];

    // RAM responder controls
    int          busy_left = 0;
    int          busy_fix  = -1;
    int          err_pct   = 0;
    bit          ovr_en    = 1'b0;
    logic [1:0]  ovr_rs    = 2'd1;
    bit          prev_en   = 1'b0;

    // reference model state
    bit          exp_ihit, exp_dhit, exp_err;
    logic [31:0] exp_iload, exp_dload;
    int          dstreak;
    bit          prev_ireq, prev_dreq, saw_ihit, saw_dhit;
    int          iwait, dwait, max_iwait, max_dwait;

    logic [15:0] ren_m, wen_m, ihit_m, dhit_m, err_m;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic ram_respond();
        ramstate = 2'd0;
        ramload  = '0;
        if (ramREN || ramWEN) begin
            if (!prev_en) busy_left = (busy_fix >= 0) ? busy_fix : int'($urandom_range(0, 3));
            if (ovr_en) ramstate = ovr_rs;
            else if (busy_left > 0) begin
                busy_left--;
                ramstate = 2'd1;
            end else if (int'($urandom_range(0, 99)) < err_pct) ramstate = 2'd3;
            else ramstate = 2'd2;
            if (ramstate == 2'd2) begin
                if (ramWEN) mem[ramaddr[8:2]] = ramstore;
                else        ramload = mem[ramaddr[8:2]];
            end
        end
    endtask

    task automatic settle();
        #1;
        ram_respond();
        #1;
    endtask

    task automatic tick();
        prev_en = ramREN | ramWEN;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_masks();
        ren_m = '0; wen_m = '0; ihit_m = '0; dhit_m = '0; err_m = '0;
    endtask

    task automatic rec(input int c);
        ren_m[c]  = ramREN;
        wen_m[c]  = ramWEN;
        ihit_m[c] = ihit;
        dhit_m[c] = dhit;
        err_m[c]  = memerr;
    endtask

    task automatic drive_reqs(input int pct);
        if (saw_ihit) iREN = 1'b0;
        if (saw_dhit) begin dREN = 1'b0; dWEN = 1'b0; end
        if (!iREN && int'($urandom_range(0, 99)) < pct) begin
            iREN  = 1'b1;
            iaddr = 32'($urandom_range(0, 15)) << 2;
        end
        if (!(dREN || dWEN) && int'($urandom_range(0, 99)) < pct) begin
            int kind;
            kind   = int'($urandom_range(0, 2));
            dREN   = (kind != 1);
            dWEN   = (kind != 0);
            daddr  = 32'h100 + (32'($urandom_range(0, 15)) << 2);
            dstore = $urandom;
        end
    endtask

    // Transaction-level expectations: who should win, what each hit returns.
    task automatic model_check();
        bit is_d, nx_i, nx_d, nx_e;
        check_eq("ihit", ihit, exp_ihit);
        check_eq("dhit", dhit, exp_dhit);
        check_eq("memerr", memerr, exp_err);
        check_eq("iload", iload, exp_iload);
        check_eq("dload", dload, exp_dload);
        check_eq("en_excl", ramREN & ramWEN, 0);
        nx_i = 0; nx_d = 0; nx_e = 0;
        if (ramREN || ramWEN) begin
            is_d = ramWEN | ramaddr[8];
            if (!prev_en)
                check_eq("winner", is_d, prev_dreq && !(prev_ireq && dstreak == C_MAX));
            if (is_d) begin
                check_eq("d_addr", ramaddr, daddr);
                check_eq("d_wen", ramWEN, dWEN);
                check_eq("d_ren", ramREN, dREN && !dWEN);
                if (dWEN) check_eq("d_store", ramstore, dstore);
            end else begin
                check_eq("i_addr", ramaddr, iaddr);
            end
            if (ramstate == 2'd2) begin
                if (is_d) begin
                    nx_d = 1;
                    if (!dWEN) exp_dload = mem[daddr[8:2]];
                    if (iREN) dstreak = (dstreak < C_MAX) ? dstreak + 1 : C_MAX;
                end else begin
                    nx_i = 1;
                    exp_iload = mem[iaddr[8:2]];
                    dstreak = 0;
                end
            end else if (ramstate == 2'd3) begin
                nx_e = 1;
            end
        end
        if (!iREN) dstreak = 0;
        exp_ihit  = nx_i;
        exp_dhit  = nx_d;
        exp_err   = nx_e;
        prev_ireq = iREN;
        prev_dreq = dREN | dWEN;
        saw_ihit  = ihit;
        saw_dhit  = dhit;
        if (ihit || !iREN) iwait = 0; else iwait++;
        if (dhit || !(dREN || dWEN)) dwait = 0; else dwait++;
        if (iwait > max_iwait) max_iwait = iwait;
        if (dwait > max_dwait) max_dwait = dwait;
    endtask

    initial begin
        logic [31:0] addr2, store2;
        int          d_since_i;
        bit          seen_first;

        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_flags", {27'd0, ihit, dhit, memerr, ramREN, ramWEN}, 0);
        check_eq("rst_iload", iload, 0);
        check_eq("rst_dload", dload, 0);
        check_eq("rst_ramaddr", ramaddr, 0);
        check_eq("rst_ramstore", ramstore, 0);
        nRST = 1'b1;
        tick();

        // fetch, two BUSY cycles then ACCESS
        clear_masks(); mem[16] = 32'h8C220004; busy_fix = 2;
        for (int c = 1; c <= 8; c++) begin
            iREN = (c <= 5); iaddr = 32'h40;
            settle(); rec(c); tick();
        end
        check_eq("t1_ihit_cycle", ihit_m, 16'h0020);
        check_eq("t1_ren_cycles", ren_m, 16'h001C);
        check_eq("t1_iload", iload, 32'h8C220004);

        // simultaneous requests, data first
        clear_masks(); mem[64] = 32'h11112222; mem[2] = 32'h33334444; busy_fix = 0; addr2 = '0;
        for (int c = 1; c <= 8; c++) begin
            iREN = (c <= 6); iaddr = 32'h08; dREN = (c <= 3); daddr = 32'h100;
            settle(); if (c == 2) addr2 = ramaddr; rec(c); tick();
        end
        check_eq("t2_first_addr", addr2, 32'h100);
        check_eq("t2_dhit_cycle", dhit_m, 16'h0008);
        check_eq("t2_ihit_cycle", ihit_m, 16'h0040);
        check_eq("t2_dload", dload, 32'h11112222);
        check_eq("t2_iload", iload, 32'h33334444);

        // write wins over read, dload untouched
        clear_masks(); store2 = '0; addr2 = '0;
        for (int c = 1; c <= 6; c++) begin
            dREN = (c <= 3); dWEN = (c <= 3); dstore = 32'hDEADBEEF; daddr = 32'h200;
            settle(); if (c == 2) begin store2 = ramstore; addr2 = ramaddr; end rec(c); tick();
        end
        check_eq("t3_wen_cycles", wen_m, 16'h0004);
        check_eq("t3_ren_cycles", ren_m, 16'h0000);
        check_eq("t3_store", store2, 32'hDEADBEEF);
        check_eq("t3_addr", addr2, 32'h200);
        check_eq("t3_dhit_cycle", dhit_m, 16'h0008);
        check_eq("t3_dload_kept", dload, 32'h11112222);

        // RAM stuck BUSY: timeout after TIMEOUT grant cycles, then withdrawal
        clear_masks(); ovr_en = 1; ovr_rs = 2'd1;
        for (int c = 1; c <= 12; c++) begin
            dREN = (c <= 10); dWEN = 0; daddr = 32'h104;
            settle(); rec(c); tick();
        end
        check_eq("t4_ren_cycles", ren_m, 16'h03FC);
        check_eq("t4_memerr_cycle", err_m, 16'h0400);
        check_eq("t4_no_dhit", dhit_m, 16'h0000);

        // ACCESS on the last allowed cycle beats the timeout
        clear_masks(); ovr_en = 0; busy_fix = C_TO - 1; mem[65] = 32'h55556666;
        for (int c = 1; c <= 12; c++) begin
            dREN = (c <= 10); daddr = 32'h104;
            settle(); rec(c); tick();
        end
        check_eq("t4b_dhit_cycle", dhit_m, 16'h0400);
        check_eq("t4b_no_memerr", err_m, 16'h0000);
        check_eq("t4b_dload", dload, 32'h55556666);

        // ERROR on first grant cycle
        clear_masks(); ovr_en = 1; ovr_rs = 2'd3;
        for (int c = 1; c <= 6; c++) begin
            iREN = (c <= 2); iaddr = 32'h0C;
            settle(); rec(c); tick();
        end
        check_eq("t5_memerr_cycle", err_m, 16'h0008);
        check_eq("t5_no_ihit", ihit_m, 16'h0000);
        check_eq("t5_ren_cycles", ren_m, 16'h0004);

        // data request withdrawn mid-grant
        clear_masks(); ovr_rs = 2'd1;
        for (int c = 1; c <= 8; c++) begin
            dREN = (c <= 3); daddr = 32'h108;
            settle(); rec(c); tick();
        end
        check_eq("t6_ren_cycles", ren_m, 16'h000C);
        check_eq("t6_no_dhit", dhit_m, 16'h0000);
        check_eq("t6_no_memerr", err_m, 16'h0000);

        // reset in the middle of a fetch grant
        iREN = 1; iaddr = 32'h10;
        for (int c = 1; c <= 2; c++) begin settle(); tick(); end
        settle();
        check_eq("t7_pre_grant", ramREN, 1);
        nRST = 1'b0;
        #1;
        check_eq("t7_rst_flags", {27'd0, ihit, dhit, memerr, ramREN, ramWEN}, 0);
        check_eq("t7_rst_addr", ramaddr, 0);
        check_eq("t7_rst_iload", iload, 0);
        tick();
        nRST = 1'b1;
        clear_masks(); ovr_en = 0; busy_fix = 0; mem[4] = 32'h77778888;
        for (int c = 1; c <= 6; c++) begin
            iREN = (c <= 3); iaddr = 32'h10;
            settle(); rec(c); tick();
        end
        check_eq("t7_ihit_cycle", ihit_m, 16'h0008);
        check_eq("t7_iload", iload, 32'h77778888);

        // randomized traffic against the reference model
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        #1; tick(); nRST = 1'b1;
        exp_ihit = 0; exp_dhit = 0; exp_err = 0; exp_iload = '0; exp_dload = '0;
        dstreak = 0; prev_ireq = 0; prev_dreq = 0; saw_ihit = 0; saw_dhit = 0;
        iwait = 0; dwait = 0; max_iwait = 0; max_dwait = 0;
        busy_fix = -1; err_pct = 6;
        for (int n = 0; n < 1500; n++) begin
            drive_reqs(40); settle(); model_check(); tick();
        end

        // both requesters saturated: fetch wins every MAX_DSTREAK data grants
        err_pct = 0; d_since_i = 0; seen_first = 0;
        for (int n = 0; n < 400; n++) begin
            drive_reqs(100); settle(); model_check();
            if (dhit) d_since_i++;
            if (ihit) begin
                if (seen_first) check_eq("streak_len", d_since_i, C_MAX);
                seen_first = 1;
                d_since_i  = 0;
            end
            tick();
        end
        check_eq("saw_fetch_wins", seen_first, 1);
        check_eq("fetch_wait_bound", max_iwait < 100, 1);
        check_eq("data_wait_bound", max_dwait < 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported unified RAM between the instruction-fetch requester and the data (lw/sw) requester of the pipeline.
- Sequences each RAM transaction through a grant FSM and latches the returned word.
- Returns one-cycle ihit/dhit pulses, which are the hit strobes the hazard logic consumes for stalls.
- Data has priority. A streak counter bounds instruction starvation, and a timeout converts a hung RAM into an error.

Parameters:
- WORD_W, 32, data and address width.
- MAX_DSTREAK, 4, consecutive data grants allowed while a fetch is pending before the fetch must win.
- TIMEOUT, 64, maximum cycles in a grant state without ACCESS before abort.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction fetch request.
- iaddr  in  WORD_W  fetch address.
- ihit  out  1  one-cycle pulse: iload valid.
- iload  out  WORD_W  fetched word, registered.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both are high.
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  write data.
- dhit  out  1  one-cycle pulse: data access complete.
- dload  out  WORD_W  read word, registered.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- memerr  out  1  one-cycle pulse on RAM ERROR or timeout.

Behaviour:
- Reset values: every output 0; state IDLE; streak 0; timer 0; iload and dload 0. Reset asserted mid-transaction aborts immediately; no hit is produced.
- States: IDLE, DGRANT, IGRANT, DRESP, IRESP.
- IDLE, winner selection:
  - Data request present (dREN|dWEN) and not (iREN && streak==MAX_DSTREAK): go to DGRANT.
  - Otherwise iREN: go to IGRANT.
  - Otherwise stay in IDLE.
  - No RAM enables are driven in IDLE.
- DGRANT:
  - ramaddr=daddr; ramWEN=dWEN; ramREN=dREN&~dWEN; ramstore=dstore.
  - On ramstate==ACCESS: dload<=ramload (reads only; a write leaves dload unchanged), go to DRESP.
- IGRANT:
  - ramaddr=iaddr; ramREN=1.
  - On ACCESS: iload<=ramload, go to IRESP.
- DRESP / IRESP:
  - dhit (resp. ihit)=1 for exactly this cycle, with no RAM enables.
  - Next state is always IDLE. Minimum latency from request to hit is 3 cycles when RAM returns ACCESS in the first grant cycle.
- Request withdrawal: if the granted requester's request drops while in a GRANT state, go to IDLE next cycle with no hit and no memerr.
- RAM error: ramstate==ERROR in a GRANT state gives memerr=1 for one cycle, a transition to IDLE, and no hit.
- Timeout:
  - The timer clears on entry to each GRANT state and increments every GRANT cycle without ACCESS.
  - When timer==TIMEOUT-1 and ACCESS is absent: memerr pulse, go to IDLE.
  - ACCESS on that same cycle takes precedence over the timeout.
- Streak counter:
  - Increments on each DGRANT→DRESP completion while iREN=1, saturating at MAX_DSTREAK.
  - Clears on IGRANT→IRESP completion, or in any cycle where iREN=0.
- Addresses and data pass through unchanged; no byte or half-word handling. Both requests asserted on the same IDLE cycle follow the priority rules above.
- At most one RAM enable is asserted per cycle, and enables are asserted only in GRANT states.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef ramstate_t (FREE, BUSY, ACCESS, ERROR);
  - typedef arb_state_t;
  - typedef word_t (WORD_W bits).
- One sub-module, arb_streak_ctr: a saturating counter with inc, clr and sat outputs, parameterised by MAX_DSTREAK.

Test Plan:
- iREN=1, iaddr=0x40; RAM returns ACCESS with 0x8C220004 after 2 BUSY cycles → ihit pulses once, at cycle 5; iload=0x8C220004; ramREN high only in IGRANT cycles.
- iREN and dREN both high with streak 0, daddr=0x100 → DGRANT first, dhit before ihit; then IGRANT for iaddr.
- iREN held, dREN held continuously, MAX_DSTREAK=4 → 4 dhit pulses, then 1 ihit; the pattern repeats, and the fetch is never starved longer than 4 data transactions.
- dWEN=1 and dREN=1, dstore=0xDEADBEEF, daddr=0x200 → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dhit pulses; dload is unchanged.
- ramstate held BUSY with TIMEOUT=8 → memerr pulses once after 8 DGRANT cycles; state returns to IDLE; no dhit. Separately, ERROR on the first grant cycle gives memerr the next edge.
- dREN dropped mid-DGRANT → IDLE, no dhit. nRST asserted mid-IGRANT → all outputs 0 immediately; a fresh request after release completes normally.
